// File: rtl/d_branch_predict_unit_pkg.sv
// Shared encodings for branch resolution and prediction:
// branch-type codes and 2-bit counter states.
package d_branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    BType_NONE = 3'd0,
    BType_BEQ  = 3'd1,
    BType_BNE  = 3'd2,
    BType_BGTZ = 3'd3,
    BType_BLTZ = 3'd4,
    BType_BGEZ = 3'd5,
    BType_BLEZ = 3'd6,
    BType_RSVD = 3'd7
  } btype_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       t
  );
    if (t)
      return (c == CTR_ST) ? c : c + 2'd1;
    return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/d_branch_predict_unit_branch_cond_eval.sv
// Combinational branch condition evaluation for the D stage.
// Sign tests treat rs as a two's-complement value.
module branch_cond_eval
  import d_branch_predict_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       btype_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             taken_o
);

  logic eq;
  logic neg;
  logic zero;

  assign eq   = (rs_i == rt_i);
  assign neg  = rs_i[WIDTH-1];
  assign zero = (rs_i == '0);

  always_comb begin
    taken_o = 1'b0;
    unique case (btype_e'(btype_i))
      BType_BEQ:  taken_o = eq;
      BType_BNE:  taken_o = ~eq;
      BType_BGTZ: taken_o = ~neg & ~zero;
      BType_BLTZ: taken_o = neg;
      BType_BGEZ: taken_o = ~neg;
      BType_BLEZ: taken_o = neg | zero;
      default:    taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_predict_unit.sv
// Branch resolution in D, 2-bit counter prediction in F,
// and saturating branch / mispredict statistics.
module d_branch_predict_unit
  import d_branch_predict_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic             d_stall,
  input  logic [2:0]       d_btype,
  input  logic [31:0]      d_pc,
  input  logic             d_pred_taken,
  input  logic [WIDTH-1:0] d_rs,
  input  logic [WIDTH-1:0] d_rt,
  output logic             d_taken,
  output logic             d_mispredict,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic             resolve;
  logic             is_br;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mp_q, mp_d;
  logic             unused_pc;

  assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0],
                       d_pc[31:IDX_W+2], d_pc[1:0]};

  branch_cond_eval #(
    .WIDTH(WIDTH)
  ) u_cond (
    .btype_i(d_btype),
    .rs_i   (d_rs),
    .rt_i   (d_rt),
    .taken_o(d_taken)
  );

  assign f_idx = f_pc[IDX_W+1:2];
  assign u_idx = d_pc[IDX_W+1:2];

  assign is_br = (d_btype != BType_NONE)
               & (d_btype != BType_RSVD);
  assign resolve = d_valid & ~d_stall & is_br;
  assign d_mispredict = resolve & (d_taken ^ d_pred_taken);

  // No bypass: F sees the pre-update counter
  assign f_pred_taken = bht_q[f_idx][1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht_q[i] <= CTR_WNT;
    end else if (resolve) begin
      bht_q[u_idx] <= ctr_next(bht_q[u_idx], d_taken);
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (clr_stats) begin
      br_d = '0;
      mp_d = '0;
    end else begin
      if (resolve && br_q != '1)
        br_d = br_q + 1'b1;
      if (d_mispredict && mp_q != '1)
        mp_d = mp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule
